// File: rtl/regfile_pkg.sv
// Shared constants, opcode/state enums and instruction field positions
// for the register-file operation sequencer.
package regfile_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;
    localparam int INSTR_W = 16;
    localparam int SHAMT_W = $clog2(DATA_W);

    // Instruction field bit positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_LDI = 3'b110,
        OP_CMP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Instruction handshake plus register-file port bundle between an
// upstream issuer / register file (master) and the sequencer (slave).
interface regfile_op_sequencer_if;
    import regfile_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  read_port_1;
    logic [ADDR_W-1:0]  read_port_2;
    logic [DATA_W-1:0]  read_data_1;
    logic [DATA_W-1:0]  read_data_2;
    logic [ADDR_W-1:0]  write_port_1;
    logic               write_enable;
    logic [DATA_W-1:0]  write_data;
    logic               flag_z;
    logic               flag_c;
    logic               busy;
    logic               done;

    modport master (
        output instr_valid, instr, read_data_1, read_data_2,
        input  instr_ready, read_port_1, read_port_2, write_port_1,
               write_enable, write_data, flag_z, flag_c, busy, done
    );

    modport slave (
        input  instr_valid, instr, read_data_1, read_data_2,
        output instr_ready, read_port_1, read_port_2, write_port_1,
               write_enable, write_data, flag_z, flag_c, busy, done
    );

endinterface

// File: rtl/regfile_alu.sv
// Combinational 8-bit ALU: result, carry/borrow/shift-out and zero.
module regfile_alu
    import regfile_pkg::*;
(
    input  opcode_e           opcode_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic [DATA_W-1:0] imm8_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;
    logic [2*DATA_W-1:0] shl_w;

    // Extended-width arithmetic so the carry/borrow lands in the top bit;
    // the shift's bit DATA_W is the last bit pushed out (0 for a zero shift).
    always_comb begin
        sum_w  = {1'b0, op_a_i} + {1'b0, op_b_i};
        diff_w = {1'b0, op_a_i} - {1'b0, op_b_i};
        shl_w  = {{DATA_W{1'b0}}, op_a_i} << op_b_i[SHAMT_W-1:0];
    end

    // Opcode select; LDI carry is ignored by the sequencer.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o = sum_w[DATA_W-1:0];
                carry_o  = sum_w[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                result_o = diff_w[DATA_W-1:0];
                carry_o  = diff_w[DATA_W];
            end
            OP_AND: result_o = op_a_i & op_b_i;
            OP_OR:  result_o = op_a_i | op_b_i;
            OP_XOR: result_o = op_a_i ^ op_b_i;
            OP_SHL: begin
                result_o = shl_w[DATA_W-1:0];
                carry_o  = shl_w[DATA_W];
            end
            OP_LDI: result_o = imm8_i;
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle sequencer: IDLE -> READ -> EXEC -> WB (LDI skips READ).
// Reads and the write-back always happen in different cycles.
module regfile_op_sequencer
    import regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    regfile_op_sequencer_if.slave  bus
);

    state_e             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  op_a_q;
    logic [DATA_W-1:0]  op_b_q;
    logic [DATA_W-1:0]  result_q;
    logic               carry_q;
    logic               zero_q;
    logic [ADDR_W-1:0]  rp1_q;
    logic [ADDR_W-1:0]  rp2_q;
    logic [ADDR_W-1:0]  wp_q;
    logic               we_q;
    logic               done_q;
    logic               flag_z_q;
    logic               flag_c_q;

    opcode_e            opcode_w;
    opcode_e            in_opcode_w;
    logic [DATA_W-1:0]  alu_result_w;
    logic               alu_carry_w;
    logic               alu_zero_w;

    assign opcode_w    = opcode_e'(instr_q[OPC_MSB:OPC_LSB]);
    assign in_opcode_w = opcode_e'(bus.instr[OPC_MSB:OPC_LSB]);

    regfile_alu u_alu (
        .opcode_i (opcode_w),
        .op_a_i   (op_a_q),
        .op_b_i   (op_b_q),
        .imm8_i   (instr_q[IMM_MSB:IMM_LSB]),
        .result_o (alu_result_w),
        .carry_o  (alu_carry_w),
        .zero_o   (alu_zero_w)
    );

    // Sequencer FSM with all register-file-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            rp1_q    <= '0;
            rp2_q    <= '0;
            wp_q     <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        // Present read indices already during READ.
                        rp1_q   <= bus.instr[RS1_MSB:RS1_LSB];
                        rp2_q   <= bus.instr[RS2_MSB:RS2_LSB];
                        state_q <= (in_opcode_w == OP_LDI) ? S_EXEC : S_READ;
                    end
                end
                S_READ: begin
                    op_a_q  <= bus.read_data_1;
                    op_b_q  <= bus.read_data_2;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    result_q <= alu_result_w;
                    carry_q  <= alu_carry_w;
                    zero_q   <= alu_zero_w;
                    wp_q     <= instr_q[RD_MSB:RD_LSB];
                    we_q     <= (opcode_w != OP_CMP);
                    done_q   <= 1'b1;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    // Flags commit only when the instruction retires.
                    flag_z_q <= zero_q;
                    if (opcode_w != OP_LDI) begin
                        flag_c_q <= carry_q;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready  = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.read_port_1  = rp1_q;
    assign bus.read_port_2  = rp2_q;
    assign bus.write_port_1 = wp_q;
    assign bus.write_enable = we_q;
    assign bus.write_data   = result_q;
    assign bus.flag_z       = flag_z_q;
    assign bus.flag_c       = flag_c_q;
    assign bus.done         = done_q;

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multi-cycle operation sequencer sitting directly upstream of the 8x8-bit register file.
- Accepts one 16-bit instruction per handshake. Drives the register file's two read ports, latches both operands, and computes an 8-bit ALU result.
- Writes the result back through the write port, which keeps reads and writes in separate cycles.
- Maintains zero/carry flags and reports completion.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register index width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [7:0] imm8 (LDI only).
- read_port_1  out  ADDR_W  register index to register file read port 1.
- read_port_2  out  ADDR_W  register index to register file read port 2.
- read_data_1  in  DATA_W  data from register file read port 1 (combinational).
- read_data_2  in  DATA_W  data from register file read port 2 (combinational).
- write_port_1  out  ADDR_W  register file write index.
- write_enable  out  1  register file write strobe.
- write_data  out  DATA_W  register file write data.
- flag_z  out  1  last result was zero.
- flag_c  out  1  carry/borrow/shift-out of the last arithmetic op.
- busy  out  1  instruction in flight.
- done  out  1  single-cycle pulse when an instruction retires.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; instruction register, operands and result are 0; all port outputs 0; write_enable=0; done=0; flag_z=0; flag_c=0; busy=0.
- Reset mid-operation: aborts the instruction immediately. No write is issued and the flags are unchanged from their reset values.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr. Go to EXEC if opcode==LDI, else READ.
  - READ: read_port_1=rs1, read_port_2=rs2, write_enable=0. Latch read_data_1/2 into opA/opB at the end of the cycle. Go to EXEC.
  - EXEC: compute result and next flags into registers; no register file access. Go to WB.
  - WB: write_port_1=rd, write_data=result. write_enable=1 except for CMP. Flags update at the end of this cycle. done=1 for exactly this cycle. Go to IDLE.
- Port exclusivity: read ports are meaningful only in READ; write_enable is asserted only in WB. A read and a write never occur in the same cycle.
- When not in READ, read ports hold the latched rs1/rs2 (don't-care to the register file).
- busy=1 in READ, EXEC and WB. instr_ready = !busy.
- Latency from the accepting edge:
  - Reg-reg ops: done in the 3rd following cycle, 4 cycles per instruction.
  - LDI: done in the 2nd following cycle, 3 cycles per instruction.
  - No back-to-back overlap: the next accept happens in IDLE after WB.
- Opcodes (all arithmetic mod 2^DATA_W):
  - 000 ADD: {c,r} = opA + opB.
  - 001 SUB: r = opA - opB; c = borrow (opA < opB unsigned).
  - 010 AND: c = 0.
  - 011 OR: c = 0.
  - 100 XOR: c = 0.
  - 101 SHL: r = opA << opB[2:0]; c = last bit shifted out, or 0 if shift amount is 0.
  - 110 LDI: r = imm8; c unchanged.
  - 111 CMP: SUB flags only; no write.
- flag_z = (r == 0) for every opcode.
- rd equal to rs1 or rs2 is legal: operands were latched in READ, so the old values are used.
- instr_valid held high while busy: no accept. The held instruction is accepted in the first IDLE cycle.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - Opcode enum (OP_ADD..OP_CMP).
  - FSM state enum (S_IDLE, S_READ, S_EXEC, S_WB).
  - Instruction field bit positions.
- One sub-module, regfile_alu: combinational {opcode, opA, opB, imm8} -> {result, carry, zero}. The FSM and registers stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, instr_ready=1 after release.
- Reset mid-op: rst asserted while in EXEC -> no write_enable pulse ever, state IDLE, flags 0.
- LDI R3,0xA5 -> write_enable=1 with write_port_1=3, write_data=0xA5, done pulses exactly 2 cycles after accept.
- ADD, with R1=0xF0 and R2=0x20 preloaded by LDI; ADD R4,R1,R2 -> read_port_1=1 and read_port_2=2 in READ; write 0x10 to R4; flag_c=1, flag_z=0; done at cycle 3.
- SUB and CMP:
  - SUB R5,R1,R1 -> write 0x00, flag_z=1, flag_c=0.
  - CMP R2,R1 (0x20-0xF0) -> write_enable never asserted, flag_c=1, flag_z=0.
- Aliasing and SHL:
  - ADD R1,R1,R1 with R1=0x81 -> writes 0x02, c=1.
  - SHL R6,R1,R2 with R2[2:0]=3 and R1=0x02 -> 0x10, c=0.
  - instr_valid held high during busy -> second instruction accepted only in IDLE.
